// File: rtl/fft_power_frame.sv
// fft_power_frame: buffers and zero-pads one audio frame, streams it through an FFT core and stores per-bin power (re^2+im^2)>>PWR_SHIFT in a readable RAM; define FFT_PWR_SAT_EN to saturate stored power instead of truncating it
module fft_power_frame #(
  parameter int N_LOG2    = 9,
  parameter int FRAME_LEN = 400,
  parameter int IN_W      = 30,
  parameter int OUT_W     = 40,
  parameter int PWR_SHIFT = 30,
  parameter int PWR_W     = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  input  logic signed [IN_W-1:0]   s_data,
  output logic                     s_ready,
  output logic                     fft_start,
  input  logic                     fft_rfd,
  output logic signed [IN_W-1:0]   fft_xn_re,
  output logic signed [IN_W-1:0]   fft_xn_im,
  input  logic                     fft_dv,
  input  logic [N_LOG2-1:0]        fft_xk_index,
  input  logic signed [OUT_W-1:0]  fft_xk_re,
  input  logic signed [OUT_W-1:0]  fft_xk_im,
  output logic                     pwr_ready,
  input  logic                     pwr_ack,
  input  logic [N_LOG2-1:0]        rd_addr,
  output logic [PWR_W-1:0]         rd_data,
  output logic [15:0]              frame_cnt
);
  localparam int N  = 1 << N_LOG2;
  localparam int SW = 2 * OUT_W + 1;
  localparam logic [N_LOG2-1:0] LAST_FILL = N_LOG2'(FRAME_LEN - 1);
  localparam logic [N_LOG2:0]   N_BINS    = (N_LOG2 + 1)'(N);
  typedef enum logic [2:0] {FILL, START, FEED, COLLECT, HOLD} state_t;
  state_t state_q, state_d;
  logic [N_LOG2-1:0] fill_cnt_q, fill_cnt_d, feed_cnt_q, feed_cnt_d, idx_q, idx_d;
  logic [N_LOG2:0] bin_cnt_q, bin_cnt_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic signed [IN_W-1:0] xn_re_q, xn_re_d;
  logic [2*OUT_W-1:0] re2_q, re2_d, im2_q, im2_d;
  logic v1_q, v1_d, s_acc, pwr_act;
  logic [SW-1:0] shifted;
  logic [PWR_W-1:0] pwr, rd_data_q, rd_data_d;
  logic signed [IN_W-1:0] buf_mem [FRAME_LEN];
  logic [PWR_W-1:0] pwr_mem [N];

  // frame sequencing, feed mux, counters and power stage 1 (squares of the core output)
  always_comb begin
    state_d     = state_q;
    fill_cnt_d  = fill_cnt_q;
    feed_cnt_d  = feed_cnt_q;
    frame_cnt_d = frame_cnt_q;
    xn_re_d     = '0;
    s_acc       = state_q == FILL && s_valid;
    pwr_act     = state_q == FEED || state_q == COLLECT;
    re2_d       = fft_xk_re * fft_xk_re;
    im2_d       = fft_xk_im * fft_xk_im;
    idx_d       = fft_xk_index;
    v1_d        = pwr_act && fft_dv;
    bin_cnt_d   = (pwr_act && v1_q && bin_cnt_q != N_BINS) ? bin_cnt_q + 1'b1 : bin_cnt_q;
    rd_data_d   = pwr_mem[rd_addr];
    case (state_q)
      FILL: if (s_acc) begin
        fill_cnt_d = (fill_cnt_q == LAST_FILL) ? '0 : fill_cnt_q + 1'b1;
        state_d    = (fill_cnt_q == LAST_FILL) ? START : FILL;
      end
      START: begin
        feed_cnt_d = '0;
        state_d    = FEED;
      end
      FEED: if (fft_rfd) begin
        xn_re_d    = (feed_cnt_q <= LAST_FILL) ? buf_mem[feed_cnt_q] : '0;
        feed_cnt_d = feed_cnt_q + 1'b1;
        state_d    = (&feed_cnt_q) ? COLLECT : FEED;
      end
      COLLECT: if (bin_cnt_d == N_BINS) begin
        state_d     = HOLD;
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
      HOLD: if (pwr_ack) begin
        state_d    = FILL;
        fill_cnt_d = '0;
        feed_cnt_d = '0;
        bin_cnt_d  = '0;
      end
      default: state_d = FILL;
    endcase
  end

  // power stage 2: sum of squares, shift, then fit to PWR_W bits
  always_comb begin
    shifted = ({1'b0, re2_q} + {1'b0, im2_q}) >> PWR_SHIFT;
`ifdef FFT_PWR_SAT_EN
    pwr = ((shifted >> PWR_W) != '0) ? '1 : PWR_W'(shifted);
`else
    pwr = PWR_W'(shifted);
`endif
  end

  // control and pipeline registers; reset aborts any frame in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      fill_cnt_q  <= '0;
      feed_cnt_q  <= '0;
      bin_cnt_q   <= '0;
      frame_cnt_q <= '0;
      xn_re_q     <= '0;
      re2_q       <= '0;
      im2_q       <= '0;
      idx_q       <= '0;
      v1_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
      feed_cnt_q  <= feed_cnt_d;
      bin_cnt_q   <= bin_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      xn_re_q     <= xn_re_d;
      re2_q       <= re2_d;
      im2_q       <= im2_d;
      idx_q       <= idx_d;
      v1_q        <= v1_d;
    end
  end

  // storage arrays and registered RAM read; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (s_acc) buf_mem[fill_cnt_q] <= s_data;
    if (v1_q) pwr_mem[idx_q] <= pwr;
    rd_data_q <= rd_data_d;
  end

  assign s_ready   = state_q == FILL;
  assign fft_start = state_q == START;
  assign pwr_ready = state_q == HOLD;
  assign fft_xn_re = xn_re_q;
  assign fft_xn_im = '0;
  assign rd_data   = rd_data_q;
  assign frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_fft_power_frame.sv
// tb_fft_power_frame: randomized bench acting as FFT core and power consumer, checked against a behavioural frame/power model
module tb_fft_power_frame;
  localparam int N = 512, FL = 400, PW = 16;
  logic clk = 1'b0, rst_n = 1'b0, s_valid = 1'b0, fft_rfd = 1'b0, fft_dv = 1'b0, pwr_ack = 1'b0;
  logic signed [29:0] s_data = '0;
  logic s_ready, fft_start, pwr_ready;
  logic signed [29:0] fft_xn_re, fft_xn_im;
  logic [8:0] fft_xk_index = '0, rd_addr = '0;
  logic signed [39:0] fft_xk_re = '0, fft_xk_im = '0;
  logic [PW-1:0] rd_data;
  logic [15:0] frame_cnt;
  int checks = 0, errors = 0, start_cnt = 0, im_bad = 0;
  logic signed [29:0] samp [FL];
  logic signed [29:0] cap [N];
  logic [PW-1:0] ram_m [N];

  fft_power_frame #(.PWR_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .fft_start(fft_start), .fft_rfd(fft_rfd), .fft_xn_re(fft_xn_re), .fft_xn_im(fft_xn_im),
    .fft_dv(fft_dv), .fft_xk_index(fft_xk_index), .fft_xk_re(fft_xk_re), .fft_xk_im(fft_xk_im),
    .pwr_ready(pwr_ready), .pwr_ack(pwr_ack), .rd_addr(rd_addr), .rd_data(rd_data), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (fft_start === 1'b1) start_cnt++;
    if (fft_xn_im !== '0) im_bad++;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got hang expected completion");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] pwr_ref(input logic signed [39:0] re, input logic signed [39:0] im);
    logic signed [81:0] a, b;
    logic [81:0] e;
    a = re;
    b = im;
    e = (a * a + b * b) / (82'd1 << 30);
`ifdef FFT_PWR_SAT_EN
    return (e > 82'hFFFF) ? 16'hFFFF : 16'(e % 82'd65536);
`else
    return 16'(e % 82'd65536);
`endif
  endfunction

  function automatic logic signed [39:0] rnd40();
    logic signed [39:0] v;
    v = 40'({$urandom(), $urandom()});
    return v >>> $urandom_range(0, 39);
  endfunction

  task automatic prep(input int kind);
    for (int i = 0; i < FL; i++)
      samp[i] = (kind == 0) ? ((i == 0) ? 30'sd32768 : 30'sd0) : (kind == 1) ? 30'sd1024 : 30'($urandom());
  endtask

  task automatic fill();
    int n = 0, g = 0;
    bit acc;
    while (n < FL && g < 5000) begin
      s_valid = $urandom_range(0, 3) != 0;
      s_data = samp[n];
      acc = s_valid && s_ready;
      @(negedge clk);
      g++;
      if (acc) n++;
    end
    s_valid = 1'b0;
    check("fill_count", 64'(n), 64'(FL));
    check("fill_s_ready_drop", s_ready, 1'b0);
    check("start_pulse", fft_start, 1'b1);
  endtask

  task automatic feed(input int mode, input bit junk);
    int got = 0, g = 0;
    bit prev = 1'b0;
    fft_rfd = 1'b0;
    while (got < N && g < 4000) begin
      if (junk) begin
        s_valid = 1'b1;
        s_data = 30'($urandom());
      end
      @(negedge clk);
      g++;
      if (prev) begin
        cap[got] = fft_xn_re;
        got++;
      end else check("xn_idle_zero", fft_xn_re, 0);
      fft_rfd = (got < N) && ((mode == 0) ? 1'b1 : (mode == 1) ? !prev : 1'($urandom_range(0, 1)));
      prev = fft_rfd;
    end
    fft_rfd = 1'b0;
    s_valid = 1'b0;
    check("feed_count", 64'(got), 64'(N));
    for (int i = 0; i < N; i++)
      if (i < FL) check("xn_sample", cap[i], samp[i]);
      else check("xn_pad_zero", cap[i], 0);
  endtask

  task automatic collect(input int kind, input int nbins);
    logic signed [39:0] re, im, acc;
    int idx;
    acc = '0;
    for (int i = 0; i < N; i++) acc += 40'(cap[i]);
    for (int i = 0; i < nbins; i++) begin
      while ($urandom_range(0, 3) == 0) begin
        fft_dv = 1'b0;
        fft_xk_re = rnd40();
        @(negedge clk);
      end
      if (i == N - 1) begin
        fft_dv = 1'b0;
        repeat (3) @(negedge clk);
        check("early_pwr_ready", pwr_ready, 1'b0);
      end
      idx = (kind == 2 && i == 7) ? 3 : i;
      re = rnd40();
      im = rnd40();
      if (kind == 0) begin re = 40'(cap[0]); im = '0; end
      if (kind == 1 && i == 0) begin re = acc; im = '0; end
      if (kind == 2 && i == 5) begin re = 40'sh7FFFFFFFFF; im = '0; end
      fft_dv = 1'b1;
      fft_xk_index = 9'(idx);
      fft_xk_re = re;
      fft_xk_im = im;
      ram_m[idx] = pwr_ref(re, im);
      @(negedge clk);
    end
    fft_dv = 1'b0;
  endtask

  task automatic wait_ready(input int fc);
    int g = 0;
    while (pwr_ready !== 1'b1 && g < 20) begin
      @(negedge clk);
      g++;
    end
    check("pwr_ready_rise", pwr_ready, 1'b1);
    check("frame_cnt", frame_cnt, 64'(fc));
    check("hold_s_ready", s_ready, 1'b0);
  endtask

  task automatic readback();
    for (int k = 0; k < N; k++) begin
      fft_dv = 1'b1;
      fft_xk_index = 9'(N - 1 - k);
      fft_xk_re = rnd40();
      fft_xk_im = rnd40();
      rd_addr = 9'(k);
      @(negedge clk);
      check("ram_bin", rd_data, ram_m[k]);
    end
    fft_dv = 1'b0;
  endtask

  task automatic read_bin(input int k, output logic [PW-1:0] d);
    rd_addr = 9'(k);
    @(negedge clk);
    d = rd_data;
  endtask

  task automatic frame(input int kind, input int mode, input bit junk, input int fc);
    prep(kind);
    fill();
    feed(mode, junk);
    collect(kind, N);
    wait_ready(fc);
    readback();
    pwr_ack = 1'b1;
    @(negedge clk);
    pwr_ack = 1'b0;
    check("ack_pwr_ready", pwr_ready, 1'b0);
    check("ack_s_ready", s_ready, 1'b1);
  endtask

  initial begin
    logic [PW-1:0] d;
    repeat (3) @(negedge clk);
    check("rst_s_ready", s_ready, 1'b1);
    check("rst_pwr_ready", pwr_ready, 1'b0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_xn_re", fft_xn_re, 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_s_ready", s_ready, 1'b1);
    check("idle_pwr_ready", pwr_ready, 1'b0);
    check("idle_no_start", 64'(start_cnt), 0);
    check("idle_frame_cnt", frame_cnt, 0);
    frame(0, 0, 1'b0, 1);
    read_bin(0, d);
    check("impulse_bin0", d, 1);
    read_bin(N - 1, d);
    check("impulse_bin_last", d, 1);
    frame(1, 0, 1'b0, 2);
    read_bin(0, d);
    check("dc_bin0", d, 156);
    frame(2, 1, 1'b1, 3);
    read_bin(5, d);
`ifdef FFT_PWR_SAT_EN
    check("bin5_sat", d, 16'hFFFF);
`else
    check("bin5_trunc", d, 16'hFC00);
`endif
    frame(3, 2, 1'b0, 4);
    check("start_pulses", 64'(start_cnt), 4);
    prep(3);
    fill();
    feed(0, 1'b0);
    collect(3, 200);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_pwr_ready", pwr_ready, 1'b0);
    check("midrst_frame_cnt", frame_cnt, 0);
    check("midrst_s_ready", s_ready, 1'b1);
    @(negedge clk);
    check("midrst_hold_low", pwr_ready, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    pwr_ack = 1'b1;
    @(negedge clk);
    pwr_ack = 1'b0;
    @(negedge clk);
    check("fill_ack_s_ready", s_ready, 1'b1);
    check("fill_ack_pwr_ready", pwr_ready, 1'b0);
    frame(0, 0, 1'b0, 1);
    check("start_pulses_end", 64'(start_cnt), 6);
    check("xn_im_zero", 64'(im_bad), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fft_power_frame.md
Name: fft_power_frame

Overview:
- Synthesizable frame engine around the streaming FFT core.
- Buffers one frame of audio samples and zero-pads it to 2^N_LOG2 points. Streams the frame into the core on rfd, then collects xk outputs on dv.
- Computes the per-bin power (re²+im²)>>PWR_SHIFT and stores it in an internal RAM that downstream feature extraction (filterbank/HMM front end) reads.
- Generalises the 512-point/400-sample/30-bit-shift flow to parametrised length, widths and shift, and adds handshakes.

Parameters:
- N_LOG2, 9, log2 of FFT points (N = 2^N_LOG2).
- FRAME_LEN, 400, samples accepted per frame; must be ≤ N. Indices FRAME_LEN..N-1 are fed as 0.
- IN_W, 30, signed sample width (xn_re).
- OUT_W, 40, signed core output width (xk_re/xk_im).
- PWR_SHIFT, 30, right shift applied to re²+im².
- PWR_W, 64, stored power width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  input sample valid.
- s_data  in  IN_W  signed input sample.
- s_ready  out  1  block accepts samples (FILL state).
- fft_start  out  1  core start pulse.
- fft_rfd  in  1  core ready-for-data.
- fft_xn_re  out  IN_W  sample to core.
- fft_xn_im  out  IN_W  constant 0.
- fft_dv  in  1  core output valid.
- fft_xk_index  in  N_LOG2  output bin index.
- fft_xk_re  in  OUT_W  signed real output.
- fft_xk_im  in  OUT_W  signed imaginary output.
- pwr_ready  out  1  power frame complete, held until ack.
- pwr_ack  in  1  consumer releases frame.
- rd_addr  in  N_LOG2  power RAM read address.
- rd_data  out  PWR_W  power at rd_addr, 1-cycle latency.
- frame_cnt  out  16  completed frames, wraps at 0xFFFF→0.

Behaviour:
- Reset: state FILL, s_ready=1, fft_start=0, fft_xn_re=0, fft_xn_im=0, pwr_ready=0, frame_cnt=0, fill/feed/bin counters 0. Reset mid-operation aborts the frame; RAM contents are not cleared.
- States: FILL → START → FEED → COLLECT → HOLD → FILL.
- FILL:
  - s_ready=1. Each s_valid cycle writes s_data to sample buffer[fill_cnt] and increments fill_cnt.
  - On the FRAME_LEN-th accept, s_ready drops the next cycle and the state goes to START.
- START: fft_start=1 for exactly one cycle; feed_cnt=0; then FEED.
- FEED:
  - Each cycle fft_rfd=1: register fft_xn_re = buffer[feed_cnt] if feed_cnt<FRAME_LEN, else 0; feed_cnt++.
  - fft_rfd=0: hold the counter and drive fft_xn_re=0.
  - After N samples are driven, go to COLLECT.
  - fft_dv arriving during FEED is also processed (core may overlap).
- Power pipeline (active in FEED/COLLECT on fft_dv):
  - Stage 1 registers re², im² (signed multiply, 2*OUT_W bits each) plus the index and valid flag.
  - Stage 2 forms the (2*OUT_W+1)-bit sum, shifts right by PWR_SHIFT, reduces to PWR_W (see feature), and writes RAM[index].
  - Latency dv → RAM write = 2 cycles.
- COLLECT: bin_cnt counts stage-2 writes. When bin_cnt reaches N, go to HOLD, set pwr_ready=1 and increment frame_cnt.
- HOLD:
  - pwr_ready=1, s_ready=0, dv ignored.
  - pwr_ack=1 → pwr_ready=0 next cycle, state FILL, counters cleared.
  - pwr_ack outside HOLD is ignored.
- s_valid outside FILL is dropped (no write, no counter change).
- Duplicate xk_index overwrites the earlier value but still counts.
- rd_addr is readable at any time; rd_data = RAM[rd_addr] registered.

Optional Feature:
- Macro FFT_PWR_SAT_EN.
- Defined: if the shifted sum ≥ 2^PWR_W, store all-ones (saturate).
- Undefined: store shifted-sum bits [PWR_W-1:0] (truncate).

Test Plan:
- Reset then idle → s_ready=1, pwr_ready=0, fft_start never asserted, frame_cnt=0.
- Impulse (s_data[0]=32768, the other 399 samples=0; core model unscaled) → fft_xn_re shows 32768 followed by 511 zeros; every bin power = 2^30>>30 = 1; pwr_ready rises; frame_cnt=1.
- DC (400 samples of 1024) → bin 0 re=409600, im=0 → power = 156; fft_xn_re=0 for feed indices 400..511.
- rfd toggled 1/0 every cycle during FEED → still exactly 512 samples driven, in order, feed_cnt frozen on rfd=0 cycles; s_valid during FEED dropped.
- PWR_W=16, model forces bin 5 xk_re=2^39-1, xk_im=0 → with FFT_PWR_SAT_EN rd_data[5]=0xFFFF; without it rd_data[5]=0xFC00.
- Assert rst_n=0 mid-COLLECT, release, run the impulse frame → pwr_ready low during reset, clean single frame afterwards, frame_cnt=1; pwr_ack pulsed in FILL has no effect.
